// File: rtl/ddr_bw_seq.sv
// Sequencer for the DDR bandwidth-test write/read AXI master pair: runs NITER
// iterations in the selected mode and accumulates per-direction busy cycles.
module ddr_bw_seq #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BURST_BEATS = 16,
    parameter int unsigned TIMEOUT_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CTRL_START,
    input  logic        CTRL_ABORT,
    input  logic [1:0]  CTRL_MODE,
    input  logic [31:0] CTRL_WBASE,
    input  logic [31:0] CTRL_RBASE,
    input  logic [31:0] CTRL_NBURST,
    input  logic [15:0] CTRL_NITER,
    output logic        STAT_BUSY,
    output logic        STAT_DONE,
    output logic [1:0]  STAT_ERR,
    output logic [15:0] STAT_ITER,
    output logic [31:0] STAT_WCYC,
    output logic [31:0] STAT_RCYC,
    output logic        WSTART_REG,
    output logic [31:0] WADDR_REG,
    output logic [31:0] WNBURST_REG,
    input  logic        WIDLE_REG,
    output logic        RSTART_REG,
    output logic [31:0] RADDR_REG,
    output logic [31:0] RNBURST_REG,
    input  logic        RDONE_REG
);

    localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS * DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_ACK, S_WAIT, S_NEXT, S_FINISH, S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           mode;
    logic [31:0]          nburst;
    logic [31:0]          stride;
    logic [15:0]          niter;
    logic                 rd_phase;
    logic                 w_run;
    logic                 r_run;
    logic [TIMEOUT_W-1:0] tmo;

    logic        start_ok, abort_ok, tmo_hit;
    logic        want_w, want_r;
    logic        w_done, r_done;
    logic        wstart_nxt, rstart_nxt, w_run_nxt, r_run_nxt;
    logic [15:0] iter_inc;

    assign WNBURST_REG = nburst;
    assign RNBURST_REG = nburst;

    always_comb begin
        want_w     = (mode == 2'd0) || (mode == 2'd3) || (mode == 2'd2 && !rd_phase);
        want_r     = (mode == 2'd1) || (mode == 2'd3) || (mode == 2'd2 && rd_phase);
        start_ok   = (state == S_IDLE) && CTRL_START && !CTRL_ABORT;
        abort_ok   = CTRL_ABORT && (state inside {S_LAUNCH, S_ACK, S_WAIT, S_NEXT});
        tmo_hit    = (tmo == '1);
        // a direction is acknowledged once its START has dropped; idle after that means done
        w_done     = w_run && !WSTART_REG && WIDLE_REG;
        r_done     = r_run && !RSTART_REG && RDONE_REG;
        wstart_nxt = WSTART_REG && WIDLE_REG;
        rstart_nxt = RSTART_REG && RDONE_REG;
        w_run_nxt  = w_run && !w_done;
        r_run_nxt  = r_run && !r_done;
        iter_inc   = STAT_ITER + 16'd1;
        state_nxt  = state;
        case (state)
            S_IDLE: begin
                if (start_ok)
                    state_nxt = (CTRL_NITER == '0 || CTRL_NBURST == '0) ? S_FINISH : S_LAUNCH;
            end
            S_LAUNCH: state_nxt = S_ACK;
            S_ACK: begin
                if (tmo_hit)
                    state_nxt = S_DRAIN;
                else if (!wstart_nxt && !rstart_nxt)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tmo_hit)
                    state_nxt = S_DRAIN;
                else if (!w_run_nxt && !r_run_nxt)
                    state_nxt = (mode == 2'd2 && !rd_phase) ? S_LAUNCH : S_NEXT;
            end
            S_NEXT:   state_nxt = (iter_inc == niter) ? S_FINISH : S_LAUNCH;
            S_FINISH: state_nxt = S_IDLE;
            S_DRAIN: begin
                if ((WIDLE_REG && RDONE_REG) || tmo_hit)
                    state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_ok)
            state_nxt = S_DRAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= '0;
            nburst     <= '0;
            stride     <= '0;
            niter      <= '0;
            rd_phase   <= 1'b0;
            w_run      <= 1'b0;
            r_run      <= 1'b0;
            tmo        <= '0;
            STAT_BUSY  <= 1'b0;
            STAT_DONE  <= 1'b0;
            STAT_ERR   <= '0;
            STAT_ITER  <= '0;
            STAT_WCYC  <= '0;
            STAT_RCYC  <= '0;
            WSTART_REG <= 1'b0;
            RSTART_REG <= 1'b0;
            WADDR_REG  <= '0;
            RADDR_REG  <= '0;
        end else begin
            if (w_run && STAT_WCYC != '1)
                STAT_WCYC <= STAT_WCYC + 32'd1;
            if (r_run && STAT_RCYC != '1)
                STAT_RCYC <= STAT_RCYC + 32'd1;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        mode      <= CTRL_MODE;
                        nburst    <= CTRL_NBURST;
                        niter     <= CTRL_NITER;
                        stride    <= CTRL_NBURST * BURST_BYTES;
                        WADDR_REG <= CTRL_WBASE;
                        RADDR_REG <= CTRL_RBASE;
                        STAT_DONE <= 1'b0;
                        STAT_ERR  <= '0;
                        STAT_ITER <= '0;
                        STAT_WCYC <= '0;
                        STAT_RCYC <= '0;
                        STAT_BUSY <= 1'b1;
                        rd_phase  <= 1'b0;
                        tmo       <= '0;
                    end
                end
                S_LAUNCH: begin
                    WSTART_REG <= want_w;
                    RSTART_REG <= want_r;
                    w_run      <= want_w;
                    r_run      <= want_r;
                    tmo        <= '0;
                end
                S_ACK, S_WAIT: begin
                    WSTART_REG <= wstart_nxt;
                    RSTART_REG <= rstart_nxt;
                    w_run      <= w_run_nxt;
                    r_run      <= r_run_nxt;
                    tmo        <= tmo + TIMEOUT_W'(1);
                    if (state == S_ACK && state_nxt == S_WAIT)
                        tmo <= '0;
                    if (state == S_WAIT && state_nxt == S_LAUNCH)
                        rd_phase <= 1'b1;
                    if (state_nxt == S_NEXT)
                        rd_phase <= 1'b0;
                    if (tmo_hit) begin
                        STAT_ERR   <= 2'd1;
                        WSTART_REG <= 1'b0;
                        RSTART_REG <= 1'b0;
                        w_run      <= 1'b0;
                        r_run      <= 1'b0;
                        tmo        <= '0;
                    end
                end
                S_NEXT: begin
                    STAT_ITER <= iter_inc;
                    WADDR_REG <= WADDR_REG + stride;
                    RADDR_REG <= RADDR_REG + stride;
                end
                S_FINISH: begin
                    STAT_BUSY <= 1'b0;
                    STAT_DONE <= (STAT_ERR == '0);
                    nburst    <= '0;
                end
                S_DRAIN: begin
                    tmo <= tmo + TIMEOUT_W'(1);
                    if (state_nxt == S_IDLE) begin
                        STAT_BUSY <= 1'b0;
                        STAT_DONE <= 1'b0;
                        nburst    <= '0;
                    end
                end
                default: ;
            endcase

            // abort overrides whatever the active state scheduled this cycle
            if (abort_ok) begin
                WSTART_REG <= 1'b0;
                RSTART_REG <= 1'b0;
                w_run      <= 1'b0;
                r_run      <= 1'b0;
                rd_phase   <= 1'b0;
                tmo        <= '0;
                STAT_ERR   <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_ddr_bw_seq.sv
// Randomized bench for ddr_bw_seq: behavioural write/read engine models plus
// a per-run expectation of addresses, iteration order and busy-cycle totals.
module tb_ddr_bw_seq;

    localparam int unsigned DW    = 64;
    localparam int unsigned BEATS = 16;

    logic        clk;
    logic        rst;
    logic        CTRL_START, CTRL_ABORT;
    logic [1:0]  CTRL_MODE;
    logic [31:0] CTRL_WBASE, CTRL_RBASE, CTRL_NBURST;
    logic [15:0] CTRL_NITER;
    logic        STAT_BUSY, STAT_DONE;
    logic [1:0]  STAT_ERR;
    logic [15:0] STAT_ITER;
    logic [31:0] STAT_WCYC, STAT_RCYC;
    logic        WSTART_REG, RSTART_REG, WIDLE_REG, RDONE_REG;
    logic [31:0] WADDR_REG, WNBURST_REG, RADDR_REG, RNBURST_REG;

    int n_cmp = 0;
    int n_bad = 0;

    // engine model state: 0 idle, 1 acknowledging, 2 busy
    int          wst, rdst, wlat, rlat, wbusy, rbusy;
    int          w_busy_fix, r_busy_fix;
    logic        w_hang;
    int unsigned ref_wcyc, ref_rcyc;
    logic        overlap;
    logic [31:0] w_addr_q[$], r_addr_q[$];
    logic [15:0] w_iter_q[$], r_iter_q[$];
    time         w_time_q[$], r_time_q[$];
    int          dir_q[$];

    ddr_bw_seq #(.DATA_WIDTH(DW), .BURST_BEATS(BEATS), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .CTRL_START(CTRL_START), .CTRL_ABORT(CTRL_ABORT), .CTRL_MODE(CTRL_MODE),
        .CTRL_WBASE(CTRL_WBASE), .CTRL_RBASE(CTRL_RBASE),
        .CTRL_NBURST(CTRL_NBURST), .CTRL_NITER(CTRL_NITER),
        .STAT_BUSY(STAT_BUSY), .STAT_DONE(STAT_DONE), .STAT_ERR(STAT_ERR),
        .STAT_ITER(STAT_ITER), .STAT_WCYC(STAT_WCYC), .STAT_RCYC(STAT_RCYC),
        .WSTART_REG(WSTART_REG), .WADDR_REG(WADDR_REG), .WNBURST_REG(WNBURST_REG),
        .WIDLE_REG(WIDLE_REG),
        .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RNBURST_REG(RNBURST_REG),
        .RDONE_REG(RDONE_REG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        WIDLE_REG = 1'b1;
        wst = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wst = 0;
                WIDLE_REG = 1'b1;
            end else begin
                if (wst == 0 && WSTART_REG && !w_hang) begin
                    wst = 1;
                    wlat = $urandom_range(0, 3);
                    w_addr_q.push_back(WADDR_REG);
                    w_time_q.push_back($time);
                    dir_q.push_back(0);
                end
                if (wst == 1) begin
                    ref_wcyc++;
                    if (wlat == 0) begin
                        WIDLE_REG = 1'b0;
                        wst = 2;
                        wbusy = (w_busy_fix != 0) ? w_busy_fix : $urandom_range(10, 100);
                    end else wlat--;
                end else if (wst == 2) begin
                    ref_wcyc++;
                    if (wbusy == 0) begin
                        WIDLE_REG = 1'b1;
                        wst = 0;
                        w_iter_q.push_back(STAT_ITER);
                    end else wbusy--;
                end
            end
        end
    end

    initial begin
        RDONE_REG = 1'b1;
        rdst = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                rdst = 0;
                RDONE_REG = 1'b1;
            end else begin
                if (rdst == 0 && RSTART_REG) begin
                    rdst = 1;
                    rlat = $urandom_range(0, 3);
                    r_addr_q.push_back(RADDR_REG);
                    r_time_q.push_back($time);
                    dir_q.push_back(1);
                end
                if (rdst == 1) begin
                    ref_rcyc++;
                    if (rlat == 0) begin
                        RDONE_REG = 1'b0;
                        rdst = 2;
                        rbusy = (r_busy_fix != 0) ? r_busy_fix : $urandom_range(10, 100);
                    end else rlat--;
                end else if (rdst == 2) begin
                    ref_rcyc++;
                    if (rbusy == 0) begin
                        RDONE_REG = 1'b1;
                        rdst = 0;
                        r_iter_q.push_back(STAT_ITER);
                    end else rbusy--;
                end
            end
        end
    end

    initial begin
        overlap = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (wst != 0 && rdst != 0) overlap = 1'b1;
        end
    end

    task automatic clear_logs();
        w_addr_q.delete(); r_addr_q.delete();
        w_iter_q.delete(); r_iter_q.delete();
        w_time_q.delete(); r_time_q.delete();
        dir_q.delete();
        ref_wcyc = 0; ref_rcyc = 0;
        overlap = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] mode, input logic [31:0] wb, input logic [31:0] rb,
                               input logic [31:0] nb, input logic [15:0] ni);
        CTRL_MODE = mode; CTRL_WBASE = wb; CTRL_RBASE = rb;
        CTRL_NBURST = nb; CTRL_NITER = ni;
        CTRL_START = 1'b1;
        tick();
        CTRL_START = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int t);
        t = 0;
        while (STAT_BUSY && t < budget) begin
            tick();
            t++;
        end
        check(tag, 32'(STAT_BUSY), 32'd0);
    endtask

    task automatic run_case(input logic [1:0] mode, input logic [31:0] wb, input logic [31:0] rb,
                            input logic [31:0] nb, input logic [15:0] ni);
        int unsigned runs, nw, nr;
        logic [31:0] stride;
        int t;
        clear_logs();
        stride = nb * 32'(BEATS * DW / 8);
        runs = (ni == 0 || nb == 0) ? 0 : int'(ni);
        nw = (mode != 2'd1) ? runs : 0;
        nr = (mode != 2'd0) ? runs : 0;
        pulse_start(mode, wb, rb, nb, ni);
        check("busy_set", 32'(STAT_BUSY), 32'd1);
        check("err_clr", 32'(STAT_ERR), 32'd0);
        check("done_clr", 32'(STAT_DONE), 32'd0);
        check("wnburst_busy", WNBURST_REG, nb);
        wait_idle("run_timeout", 5000, t);
        if (runs == 0) check("fast_done", 32'(t <= 2), 32'd1);
        check("done", 32'(STAT_DONE), 32'd1);
        check("err", 32'(STAT_ERR), 32'd0);
        check("iter", 32'(STAT_ITER), runs);
        check("wcyc", STAT_WCYC, ref_wcyc);
        check("rcyc", STAT_RCYC, ref_rcyc);
        check("wnburst_idle", WNBURST_REG | RNBURST_REG, 32'd0);
        check("n_wstart", w_addr_q.size(), nw);
        check("n_rstart", r_addr_q.size(), nr);
        for (int i = 0; i < w_addr_q.size() && i < int'(nw); i++) begin
            check("waddr", w_addr_q[i], wb + 32'(i) * stride);
            check("w_iter_at_done", 32'(w_iter_q[i]), 32'(i));
        end
        for (int i = 0; i < r_addr_q.size() && i < int'(nr); i++) begin
            check("raddr", r_addr_q[i], rb + 32'(i) * stride);
            check("r_iter_at_done", 32'(r_iter_q[i]), 32'(i));
        end
        if (mode == 2'd2) begin
            check("m2_overlap", 32'(overlap), 32'd0);
            for (int k = 0; k < dir_q.size(); k++)
                check("m2_order", 32'(dir_q[k]), 32'(k % 2));
        end
        if (mode == 2'd3) begin
            for (int i = 0; i < w_time_q.size() && i < r_time_q.size(); i++)
                check("m3_same_start", 32'(w_time_q[i] == r_time_q[i]), 32'd1);
        end
    endtask

    initial begin
        int t;
        rst = 1'b1;
        CTRL_START = 1'b0; CTRL_ABORT = 1'b0; CTRL_MODE = '0;
        CTRL_WBASE = '0; CTRL_RBASE = '0; CTRL_NBURST = '0; CTRL_NITER = '0;
        w_hang = 1'b0; w_busy_fix = 0; r_busy_fix = 0;
        clear_logs();
        repeat (3) tick();
        check("rst_busy", 32'(STAT_BUSY), 32'd0);
        check("rst_done_err", {29'd0, STAT_DONE, STAT_ERR}, 32'd0);
        check("rst_starts", {30'd0, WSTART_REG, RSTART_REG}, 32'd0);
        check("rst_cyc", STAT_WCYC | STAT_RCYC | 32'(STAT_ITER), 32'd0);
        check("rst_addr", WADDR_REG | RADDR_REG | WNBURST_REG, 32'd0);
        rst = 1'b0;
        tick();

        run_case(2'd0, 32'h1000_0000, 32'h0, 32'd64, 16'd3);
        run_case(2'd2, 32'h2000_0000, 32'h3000_0000, 32'd64, 16'd2);
        w_busy_fix = 90; r_busy_fix = 40;
        run_case(2'd3, 32'h4000_0000, 32'h5000_0000, 32'd64, 16'd2);
        w_busy_fix = 0; r_busy_fix = 0;
        run_case(2'd3, 32'h1234_0000, 32'h5678_0000, 32'd8, 16'd0);
        run_case(2'd2, 32'h1234_0000, 32'h5678_0000, 32'd0, 16'd3);
        run_case(2'd1, 32'hABCD_0000, 32'h0000_F000, 32'd3, 16'd2);

        repeat (6) begin
            logic [1:0]  m;
            logic [31:0] nb;
            m  = 2'($urandom_range(0, 3));
            nb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_case(m, $urandom, $urandom, nb, 16'($urandom_range(1, 3)));
        end

        // write engine never acknowledges: handshake timeout
        clear_logs();
        w_hang = 1'b1;
        pulse_start(2'd0, 32'h0, 32'h0, 32'd1, 16'd1);
        repeat (200) tick();
        check("tmo_not_yet", 32'(STAT_ERR), 32'd0);
        check("tmo_wstart_held", 32'(WSTART_REG), 32'd1);
        wait_idle("tmo_idle", 200, t);
        check("tmo_err", 32'(STAT_ERR), 32'd1);
        check("tmo_done", 32'(STAT_DONE), 32'd0);
        check("tmo_wstart_drop", 32'(WSTART_REG), 32'd0);

        // abort while START is still held in ACK
        pulse_start(2'd3, 32'h0, 32'h0, 32'd1, 16'd1);
        repeat (10) tick();
        CTRL_ABORT = 1'b1;
        tick();
        CTRL_ABORT = 1'b0;
        check("abort_ack_wstart", 32'(WSTART_REG), 32'd0);
        check("abort_ack_err", 32'(STAT_ERR), 32'd2);
        wait_idle("abort_ack_idle", 300, t);
        check("abort_ack_done", 32'(STAT_DONE), 32'd0);
        w_hang = 1'b0;
        tick();

        // abort during WAIT of the second iteration; drain until the engine idles
        clear_logs();
        w_busy_fix = 100;
        pulse_start(2'd0, 32'h1000_0000, 32'h0, 32'd64, 16'd3);
        t = 0;
        while (!(w_addr_q.size() == 2 && wst == 2) && t < 2000) begin
            tick();
            t++;
        end
        check("abort_reach_iter2", 32'(t < 2000), 32'd1);
        repeat (5) tick();
        CTRL_ABORT = 1'b1;
        tick();
        CTRL_ABORT = 1'b0;
        check("abort_wait_starts", {30'd0, WSTART_REG, RSTART_REG}, 32'd0);
        check("abort_wait_err", 32'(STAT_ERR), 32'd2);
        check("abort_wait_iter", 32'(STAT_ITER), 32'd1);
        check("abort_draining", 32'(STAT_BUSY), 32'd1);
        wait_idle("abort_drain_idle", 300, t);
        check("abort_engine_idle", 32'(WIDLE_REG), 32'd1);
        check("abort_done", 32'(STAT_DONE), 32'd0);
        w_busy_fix = 0;
        run_case(2'd0, 32'hFFFF_F000, 32'h0, 32'd64, 16'd2);

        // simultaneous start and abort in IDLE: start ignored
        CTRL_START = 1'b1; CTRL_ABORT = 1'b1;
        tick();
        CTRL_START = 1'b0; CTRL_ABORT = 1'b0;
        tick();
        check("start_abort_busy", 32'(STAT_BUSY), 32'd0);
        check("start_abort_done", 32'(STAT_DONE), 32'd1);

        // asynchronous reset mid-run
        clear_logs();
        pulse_start(2'd3, 32'h0, 32'h0, 32'd2, 16'd2);
        t = 0;
        while (!WSTART_REG && t < 20) begin
            tick();
            t++;
        end
        #1 rst = 1'b1;
        #1;
        check("arst_starts", {30'd0, WSTART_REG, RSTART_REG}, 32'd0);
        check("arst_busy", 32'(STAT_BUSY), 32'd0);
        check("arst_addr", WADDR_REG | WNBURST_REG, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_case(2'd2, 32'h0000_1000, 32'h8000_0000, 32'd2, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
